// File: rtl/calc_pkg.sv
// Shared encodings for the calculator controller: datapath commands, compute
// selects, FSM state encoding and LED phase values.
package calc_pkg;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD_A  = 3'b001;
  localparam logic [2:0] OP_LOAD_B  = 3'b011;
  localparam logic [2:0] OP_COMPUTE = 3'b101;

  localparam logic [1:0] CMP_ADD = 2'b00;
  localparam logic [1:0] CMP_SUB = 2'b01;
  localparam logic [1:0] CMP_MUL = 2'b10;
  localparam logic [1:0] CMP_DIV = 2'b11;

  localparam logic [1:0] PH_A   = 2'b00;
  localparam logic [1:0] PH_B   = 2'b01;
  localparam logic [1:0] PH_OP  = 2'b10;
  localparam logic [1:0] PH_RES = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_WAIT_B  = 3'd2,
    ST_LOAD_B  = 3'd3,
    ST_WAIT_OP = 3'd4,
    ST_EXEC    = 3'd5,
    ST_SHOW    = 3'd6
  } state_e;

  function automatic logic [2:0] state_op(state_e s);
    case (s)
      ST_LOAD_A: state_op = OP_LOAD_A;
      ST_LOAD_B: state_op = OP_LOAD_B;
      ST_EXEC:   state_op = OP_COMPUTE;
      default:   state_op = OP_NOP;
    endcase
  endfunction

  function automatic logic [1:0] state_phase(state_e s);
    case (s)
      ST_WAIT_A, ST_LOAD_A:           state_phase = PH_A;
      ST_WAIT_B, ST_LOAD_B:           state_phase = PH_B;
      ST_WAIT_OP, ST_EXEC:            state_phase = PH_OP;
      default:                        state_phase = PH_RES;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer plus one-cycle rising-edge pulse; a level held through
// reset never produces a pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   sync_w;

  assign sync_w = sync_q[SYNC_STAGES-1];

  // prev stays high until the synchronizer has flushed its reset zeros, so a
  // button already held at reset release is treated as an old level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= fill_q[SYNC_STAGES-1] ? sync_w : 1'b1;
    end
  end

  assign pulse_o = fill_q[SYNC_STAGES-1] & sync_w & ~prev_q;

endmodule

// File: rtl/calculator_controller.sv
// Sequences operand/operation entry from board buttons into datapath commands
// and reports phase, result-valid and error as registered LED outputs.
module calculator_controller
  import calc_pkg::*;
#(
  parameter int TIMEOUT     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       clear,
  input  logic [3:0] sw_data,
  input  logic [1:0] sw_op,
  input  logic       dp_done,
  input  logic       dp_div_by_zero,
  output logic [3:0] data_in,
  output logic [2:0] op_code,
  output logic [1:0] compute_op,
  output logic [1:0] phase,
  output logic       result_valid,
  output logic       error
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic ent_pulse, clr_pulse;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
    .clk(clk), .reset(reset), .btn_i(enter), .pulse_o(ent_pulse)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk(clk), .reset(reset), .btn_i(clear), .pulse_o(clr_pulse)
  );

  state_e        state_q, state_d;
  logic [3:0]    data_in_q, data_in_d;
  logic [2:0]    op_code_q, op_code_d;
  logic [1:0]    cop_q, cop_d;
  logic [1:0]    phase_q, phase_d;
  logic          rv_q, rv_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_WAIT_A;
      data_in_q <= '0;
      op_code_q <= OP_NOP;
      cop_q     <= CMP_ADD;
      phase_q   <= PH_A;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_in_q <= data_in_d;
      op_code_q <= op_code_d;
      cop_q     <= cop_d;
      phase_q   <= phase_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_in_d = data_in_q;
    cop_d     = cop_q;
    rv_d      = rv_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (clr_pulse) begin
      state_d = ST_WAIT_A;
      rv_d    = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_A: if (ent_pulse) begin
          data_in_d = sw_data;
          state_d   = ST_LOAD_A;
        end
        ST_LOAD_A: state_d = ST_WAIT_B;
        ST_WAIT_B: if (ent_pulse) begin
          data_in_d = sw_data;
          state_d   = ST_LOAD_B;
        end
        ST_LOAD_B: state_d = ST_WAIT_OP;
        ST_WAIT_OP: if (ent_pulse) begin
          cop_d   = sw_op;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          cnt_d = cnt_q + CW'(1);
          // done seen on the timeout cycle still counts as a real result
          if (dp_done) begin
            state_d = ST_SHOW;
            rv_d    = 1'b1;
            err_d   = dp_div_by_zero;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_SHOW;
            rv_d    = 1'b0;
            err_d   = 1'b1;
          end
        end
        ST_SHOW: if (ent_pulse) begin
          state_d = ST_WAIT_A;
          rv_d    = 1'b0;
          err_d   = 1'b0;
        end
        default: state_d = ST_WAIT_A;
      endcase
    end
    op_code_d = state_op(state_d);
    phase_d   = state_phase(state_d);
  end

  assign data_in      = data_in_q;
  assign op_code      = op_code_q;
  assign compute_op   = cop_q;
  assign phase        = phase_q;
  assign result_valid = rv_q;
  assign error        = err_q;

endmodule

// File: tb/tb_calculator_controller.sv
// Scoreboard bench for calculator_controller with a small datapath model.
module tb_calculator_controller;
  import calc_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int SYNC    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0, clear = 1'b0;
  logic [3:0] sw_data = '0;
  logic [1:0] sw_op = '0;
  logic       dp_done = 1'b0, dp_div_by_zero = 1'b0;
  logic [3:0] data_in;
  logic [2:0] op_code;
  logic [1:0] compute_op, phase;
  logic       result_valid, error;

  calculator_controller #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .enter(enter), .clear(clear),
    .sw_data(sw_data), .sw_op(sw_op), .dp_done(dp_done),
    .dp_div_by_zero(dp_div_by_zero), .data_in(data_in), .op_code(op_code),
    .compute_op(compute_op), .phase(phase), .result_valid(result_valid),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] data;
    logic [1:0] cop;
    int         len;
  } cmd_t;

  typedef struct {
    logic rv;
    logic err;
  } res_t;

  cmd_t cmd_q[$];
  res_t res_q[$];
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // datapath model: done after done_at COMPUTE cycles when enabled
  int   done_at = 2;
  logic done_en = 1'b1, dz = 1'b0;
  int   ex_cnt = 0;
  always @(negedge clk) begin
    if (op_code == OP_COMPUTE) ex_cnt++;
    else ex_cnt = 0;
    dp_done        = done_en && (ex_cnt == done_at);
    dp_div_by_zero = dz && done_en && (ex_cnt == done_at);
  end

  // monitor: each new command and each arrival in RESULT phase is scored
  logic [2:0] prev_op = OP_NOP;
  logic [1:0] prev_ph = PH_A;
  int         run = 0;
  cmd_t       cur;
  res_t       r;
  always @(negedge clk) begin
    if (!reset) begin
      prev_op = OP_NOP;
      prev_ph = PH_A;
      run     = 0;
      cur.len = 0;
    end else begin
      if (op_code != prev_op) begin
        if (prev_op != OP_NOP && cur.len != 0) chk("cmd_len", run, cur.len);
        if (op_code != OP_NOP) begin
          if (cmd_q.size() == 0) begin
            chk("unexp_cmd", op_code, OP_NOP);
            cur.len = 0;
          end else begin
            cur = cmd_q.pop_front();
            chk("cmd_op", op_code, cur.op);
            chk("cmd_data", data_in, cur.data);
            chk("cmd_cop", compute_op, cur.cop);
          end
          run = 0;
        end
      end
      if (op_code != OP_NOP) run++;
      if (phase == PH_RES && prev_ph != PH_RES) begin
        if (res_q.size() == 0) chk("unexp_res", phase, prev_ph);
        else begin
          r = res_q.pop_front();
          chk("res_valid", result_valid, r.rv);
          chk("res_err", error, r.err);
          chk("res_op", op_code, OP_NOP);
        end
      end
      prev_op = op_code;
      prev_ph = phase;
    end
  end

  logic [3:0] m_data = '0;
  logic [1:0] m_cop  = '0;

  task automatic press();
    @(posedge clk); #1 enter = 1'b1;
    repeat (4) @(posedge clk);
    #1 enter = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic enter_a(input logic [3:0] v);
    sw_data = v; m_data = v;
    cmd_q.push_back('{OP_LOAD_A, v, m_cop, 1});
    press();
  endtask

  task automatic enter_b(input logic [3:0] v);
    sw_data = v; m_data = v;
    cmd_q.push_back('{OP_LOAD_B, v, m_cop, 1});
    press();
  endtask

  task automatic enter_op(input logic [1:0] o, input int len, input logic rv, input logic er);
    sw_op = o; m_cop = o;
    cmd_q.push_back('{OP_COMPUTE, m_data, o, len});
    res_q.push_back('{rv, er});
    press();
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with enter held through release
    enter = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op", op_code, OP_NOP);
    chk("rst_phase", phase, PH_A);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_err", error, 1'b0);
    chk("rst_data", data_in, 4'd0);
    chk("rst_cop", compute_op, 2'd0);
    reset = 1'b1;
    settle(8);
    chk("held_phase", phase, PH_A);
    chk("held_op", op_code, OP_NOP);
    enter = 1'b0;
    settle(4);

    // 7 + 3, done after 2 cycles
    done_en = 1'b1; done_at = 2; dz = 1'b0;
    enter_a(4'd7);
    chk("phB", phase, PH_B);
    enter_b(4'd3);
    chk("phOP", phase, PH_OP);
    enter_op(CMP_ADD, 2, 1'b1, 1'b0);
    settle(4);
    chk("add_phase", phase, PH_RES);
    chk("add_rv", result_valid, 1'b1);
    chk("add_err", error, 1'b0);
    press();
    chk("ret_phase", phase, PH_A);
    chk("ret_rv", result_valid, 1'b0);

    // divide by zero
    dz = 1'b1; done_at = 3;
    enter_a(4'd3);
    enter_b(4'd0);
    enter_op(CMP_DIV, 3, 1'b1, 1'b1);
    settle(4);
    chk("dz_rv", result_valid, 1'b1);
    chk("dz_err", error, 1'b1);
    press();
    chk("dz_ret_phase", phase, PH_A);
    chk("dz_ret_rv", result_valid, 1'b0);
    chk("dz_ret_err", error, 1'b0);

    // timeout: done never arrives
    dz = 1'b0; done_en = 1'b0;
    enter_a(4'd5);
    enter_b(4'd2);
    enter_op(CMP_MUL, TIMEOUT, 1'b0, 1'b1);
    settle(TIMEOUT + 4);
    chk("to_phase", phase, PH_RES);
    chk("to_rv", result_valid, 1'b0);
    chk("to_err", error, 1'b1);
    chk("to_op", op_code, OP_NOP);
    press();

    // switch change after capture, then clear beats enter in WAIT_OP
    enter_a(4'd9);
    sw_data = 4'd4;
    settle(3);
    chk("hold_data", data_in, 4'd9);
    enter_b(4'd1);
    @(posedge clk); #1 enter = 1'b1; clear = 1'b1;
    settle(5);
    chk("clr_phase", phase, PH_A);
    chk("clr_op", op_code, OP_NOP);
    chk("clr_data", data_in, 4'd1);
    chk("clr_cop", compute_op, CMP_MUL);
    enter = 1'b0; clear = 1'b0;
    settle(4);

    // async reset in the middle of EXEC
    enter_a(4'd2);
    enter_b(4'd2);
    sw_op = CMP_SUB;
    cmd_q.push_back('{OP_COMPUTE, 4'd2, CMP_SUB, 0});
    @(posedge clk); #1 enter = 1'b1;
    begin
      int w = 0;
      while (op_code != OP_COMPUTE && w < 20) begin
        @(posedge clk); #1; w++;
      end
      if (op_code != OP_COMPUTE) chk("exec_wait", op_code, OP_COMPUTE);
    end
    repeat (3) @(posedge clk);
    #2 chk("pre_rst_phase", phase, PH_OP);
    reset = 1'b0;
    #1;
    chk("arst_op", op_code, OP_NOP);
    chk("arst_phase", phase, PH_A);
    chk("arst_rv", result_valid, 1'b0);
    chk("arst_data", data_in, 4'd0);
    enter = 1'b0;
    settle(2);
    reset = 1'b1;
    settle(6);

    chk("cmd_q_left", cmd_q.size(), 0);
    chk("res_q_left", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
